sequenciador_apresentacao: RTL and testbench

SEQUENCIADOR_APRESENTACAO -- requirements
Module: sequenciador_apresentacao

---
 rtl/sequenciador_pkg.sv | 34 +++
 rtl/contador_ticks.sv | 29 ++
 rtl/sequenciador_apresentacao.sv | 146 ++++++++++++++
 tb/tb_sequenciador_apresentacao.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_pkg.sv
// Shared types and timing helpers for the note-presentation sequencer.
// Durations are expressed in clock cycles derived from the clock frequency.
package sequenciador_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_INICIAL,
        LE_MEMORIA,
        TOCA,
        PAUSA,
        FIM
    } estado_t;

    localparam int TEMPO_W = 2;
    localparam int NOTA_W  = 4;
    localparam int N_LEDS  = 12;

    function automatic int unsigned t_meio(input int unsigned freq);
        return freq / 2;
    endfunction

    // Duration code 0..3 maps to 1..4 half-second units.
    function automatic int unsigned duracao(input int unsigned freq,
                                            input logic [TEMPO_W-1:0] tempo);
        return (32'(tempo) + 32'd1) * t_meio(freq);
    endfunction

    function automatic logic [N_LEDS-1:0] decodifica_nota(input logic [NOTA_W-1:0] nota);
        logic [N_LEDS-1:0] um;
        um = 1;
        return (nota < NOTA_W'(N_LEDS)) ? (um << nota) : '0;
    endfunction

endpackage

// File: rtl/contador_ticks.sv
// Loadable down-counter that parks at zero; fim flags the last cycle of an interval.
module contador_ticks
    import sequenciador_pkg::*;
#(
    parameter int LARGURA = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carrega,
    input  logic               habilita,
    input  logic [LARGURA-1:0] valor,
    output logic               fim
);

    logic [LARGURA-1:0] contagem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (carrega) begin
            contagem <= valor;
        end else if (habilita && contagem != '0) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign fim = (contagem == '0);

endmodule

// File: rtl/sequenciador_apresentacao.sv
// Plays notes from memory addresses 0..rodada with timed note and pause intervals.
// Optional feature: SEQUENCIADOR_APRESENTA_ULTIMA_EN enables modo_ultima (play only address rodada).
module sequenciador_apresentacao
    import sequenciador_pkg::*;
#(
    parameter int CLOCK_FREQ = 5000,
    parameter int ADDR_W     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               parar,
    input  logic               modo_ultima,
    input  logic [ADDR_W-1:0]  rodada,
    input  logic [NOTA_W-1:0]  mem_nota,
    input  logic [TEMPO_W-1:0] mem_tempo,
    output logic [ADDR_W-1:0]  endereco,
    output logic [N_LEDS-1:0]  leds,
    output logic               buzzer_en,
    output logic               ocupado,
    output logic               pronto
);

    localparam int unsigned T_MEIO = t_meio(CLOCK_FREQ);
    localparam int          CONT_W = $clog2(4 * T_MEIO + 1);

    estado_t             estado;
    logic [ADDR_W-1:0]   rodada_reg;
    logic [ADDR_W-1:0]   endereco_inicial;
    logic                carrega;
    logic                habilita;
    logic                fim_contagem;
    logic [CONT_W-1:0]   valor_carga;

`ifdef SEQUENCIADOR_APRESENTA_ULTIMA_EN
    assign endereco_inicial = modo_ultima ? rodada : '0;
`else
    logic unused_modo_ultima;
    assign unused_modo_ultima = modo_ultima;
    assign endereco_inicial   = '0;
`endif

    // The counter is loaded with N-1 on the edge that enters an N-cycle interval.
    always_comb begin
        carrega     = 1'b0;
        valor_carga = '0;
        if (!parar) begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        carrega     = 1'b1;
                        valor_carga = CONT_W'(T_MEIO - 1);
                    end
                end
                LE_MEMORIA: begin
                    carrega     = 1'b1;
                    valor_carga = CONT_W'(duracao(CLOCK_FREQ, mem_tempo) - 1);
                end
                TOCA: begin
                    if (fim_contagem && endereco != rodada_reg) begin
                        carrega     = 1'b1;
                        valor_carga = CONT_W'(T_MEIO - 1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign habilita = (estado == ESPERA_INICIAL) || (estado == TOCA) || (estado == PAUSA);

    contador_ticks #(
        .LARGURA (CONT_W)
    ) u_contador (
        .clock    (clock),
        .reset    (reset),
        .carrega  (carrega),
        .habilita (habilita),
        .valor    (valor_carga),
        .fim      (fim_contagem)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= OCIOSO;
            endereco   <= '0;
            rodada_reg <= '0;
            leds       <= '0;
            buzzer_en  <= 1'b0;
            ocupado    <= 1'b0;
            pronto     <= 1'b0;
        end else if (parar) begin
            estado    <= OCIOSO;
            leds      <= '0;
            buzzer_en <= 1'b0;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    pronto <= 1'b0;
                    if (iniciar) begin
                        estado     <= ESPERA_INICIAL;
                        endereco   <= endereco_inicial;
                        rodada_reg <= rodada;
                        ocupado    <= 1'b1;
                    end
                end
                ESPERA_INICIAL: begin
                    if (fim_contagem) estado <= LE_MEMORIA;
                end
                LE_MEMORIA: begin
                    // Memory data for endereco is valid now; capture it into the display.
                    leds      <= decodifica_nota(mem_nota);
                    buzzer_en <= (mem_nota < NOTA_W'(N_LEDS));
                    estado    <= TOCA;
                end
                TOCA: begin
                    if (fim_contagem) begin
                        leds      <= '0;
                        buzzer_en <= 1'b0;
                        if (endereco == rodada_reg) begin
                            estado  <= FIM;
                            pronto  <= 1'b1;
                            ocupado <= 1'b0;
                        end else begin
                            estado <= PAUSA;
                        end
                    end
                end
                PAUSA: begin
                    if (fim_contagem) begin
                        endereco <= endereco + 1'b1;
                        estado   <= LE_MEMORIA;
                    end
                end
                FIM: begin
                    pronto <= 1'b0;
                    estado <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_apresentacao.sv
// Bench for sequenciador_apresentacao: per-cycle comparison against a timeline model.
// Honours SEQUENCIADOR_APRESENTA_ULTIMA_EN in the model when it is defined.
module tb_sequenciador_apresentacao;

    localparam int CLOCK_FREQ = 5000;
    localparam int ADDR_W     = 4;
    localparam int T_MEIO     = CLOCK_FREQ / 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              iniciar = 1'b0;
    logic              parar = 1'b0;
    logic              modo_ultima = 1'b0;
    logic [ADDR_W-1:0] rodada = '0;
    logic [3:0]        mem_nota;
    logic [1:0]        mem_tempo;
    logic [ADDR_W-1:0] endereco;
    logic [11:0]       leds;
    logic              buzzer_en;
    logic              ocupado;
    logic              pronto;

    logic [3:0] mem_n [16];
    logic [1:0] mem_t [16];

    assign mem_nota  = mem_n[endereco];
    assign mem_tempo = mem_t[endereco];

    sequenciador_apresentacao #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .parar       (parar),
        .modo_ultima (modo_ultima),
        .rodada      (rodada),
        .mem_nota    (mem_nota),
        .mem_tempo   (mem_tempo),
        .endereco    (endereco),
        .leds        (leds),
        .buzzer_en   (buzzer_en),
        .ocupado     (ocupado),
        .pronto      (pronto)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] leds;
        logic        buz;
        logic        ocup;
        logic        pronto;
        logic        chk_end;
        logic [3:0]  end_v;
    } esperado_t;

    esperado_t fila[$];
    int n_tests = 0;
    int n_fail  = 0;
    int pos     = 0;

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
        end
    endtask

    task automatic empilha(input int n, input logic [11:0] l, input logic b,
                           input logic o, input logic p, input logic [3:0] e);
        esperado_t r;
        r.leds = l; r.buz = b; r.ocup = o; r.pronto = p; r.chk_end = 1'b1; r.end_v = e;
        repeat (n) fila.push_back(r);
    endtask

    // Expected output timeline, one entry per cycle after the start edge.
    task automatic modelo(input int r);
        int addrs[$];
        int a, n, t, dur;
        logic [11:0] l;
`ifdef SEQUENCIADOR_APRESENTA_ULTIMA_EN
        if (modo_ultima) addrs.push_back(r);
        else for (int k = 0; k <= r; k++) addrs.push_back(k);
`else
        for (int k = 0; k <= r; k++) addrs.push_back(k);
`endif
        empilha(T_MEIO, 12'h0, 1'b0, 1'b1, 1'b0, 4'(addrs[0]));
        for (int i = 0; i < addrs.size(); i++) begin
            a   = addrs[i];
            n   = int'(mem_n[a]);
            t   = int'(mem_t[a]);
            dur = (t + 1) * T_MEIO;
            l   = (n < 12) ? 12'(1 << n) : 12'h0;
            empilha(1, 12'h0, 1'b0, 1'b1, 1'b0, 4'(a));
            empilha(dur, l, n < 12, 1'b1, 1'b0, 4'(a));
            if (i != addrs.size() - 1) empilha(T_MEIO, 12'h0, 1'b0, 1'b1, 1'b0, 4'(a));
        end
        empilha(1, 12'h0, 1'b0, 1'b0, 1'b1, 4'(addrs[addrs.size()-1]));
    endtask

    always @(negedge clock) begin
        esperado_t e;
        if (reset) begin
            if (fila.size() > 0) begin
                e = fila.pop_front();
            end else begin
                e.leds = 12'h0; e.buz = 1'b0; e.ocup = 1'b0; e.pronto = 1'b0;
                e.chk_end = 1'b0; e.end_v = 4'h0;
            end
            chk("saidas", {17'b0, leds, buzzer_en, ocupado, pronto},
                          {17'b0, e.leds, e.buz, e.ocup, e.pronto});
            if (e.chk_end) chk("endereco", {28'b0, endereco}, {28'b0, e.end_v});
        end
    end

    task automatic inicia();
        @(posedge clock); #1 iniciar = 1'b1;
        @(posedge clock); #1 iniciar = 1'b0;
        modelo(int'(rodada));
        pos = 0;
    endtask

    task automatic ate(input int k);
        while (pos < k) begin
            @(negedge clock);
            pos++;
        end
        #1;
    endtask

    task automatic espera_fim(input int limite);
        int c = 0;
        while (fila.size() > 0 && c < limite) begin
            @(negedge clock);
            c++;
        end
        if (fila.size() > 0) begin
            chk("timeout", fila.size(), 0);
            fila.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_n[i] = 4'd0;
            mem_t[i] = 2'd0;
        end
        reset = 1'b0;
        #3;
        chk("reset_leds", {20'b0, leds}, 32'h0);
        chk("reset_ctrl", {29'b0, buzzer_en, ocupado, pronto}, 32'h0);
        chk("reset_end", {28'b0, endereco}, 32'h0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (5) @(negedge clock);

        // Single note at address 0
        mem_n[0] = 4'd2; mem_t[0] = 2'd2; rodada = 4'd0;
        inicia();
        chk("s1_modelo_len", fila.size(), 10002);
        ate(2501);  chk("s1_leitura", {19'b0, leds, ocupado}, 32'h1);
        ate(2502);  chk("s1_toca_ini", {19'b0, leds, buzzer_en}, {19'b0, 12'b000000000100, 1'b1});
        ate(10001); chk("s1_toca_fim", {20'b0, leds}, 32'h4);
        ate(10002); chk("s1_pronto", {19'b0, leds, ocupado, pronto}, 32'h1);
        ate(10003); chk("s1_pronto_unico", {31'b0, pronto}, 32'h0);
        espera_fim(30000);

        // Two notes; modo_ultima set; rodada changed after start must not matter
        mem_n[1] = 4'd4; mem_t[1] = 2'd3; rodada = 4'd1; modo_ultima = 1'b1;
        inicia();
        rodada = 4'd0;
`ifdef SEQUENCIADOR_APRESENTA_ULTIMA_EN
        chk("s2_modelo_len", fila.size(), 12502);
        ate(2501);  chk("s2_end_ultima", {28'b0, endereco}, 32'h1);
        ate(2502);  chk("s2_nota_ultima", {20'b0, leds}, 32'h010);
        ate(12502); chk("s2_pronto", {31'b0, pronto}, 32'h1);
`else
        chk("s2_modelo_len", fila.size(), 22503);
        ate(2502);  chk("s2_nota0", {20'b0, leds}, 32'h004);
        ate(10002); chk("s2_pausa", {27'b0, leds == 12'h0, ocupado, endereco}, {27'b0, 1'b1, 1'b1, 4'h0});
        ate(12502); chk("s2_leitura1", {28'b0, endereco}, 32'h1);
        ate(12503); chk("s2_nota1", {20'b0, leds}, 32'h010);
        ate(22503); chk("s2_pronto", {31'b0, pronto}, 32'h1);
`endif
        espera_fim(30000);
        modo_ultima = 1'b0;

        // Abort mid-note with a simultaneous start request
        mem_n[0] = 4'd5; mem_t[0] = 2'd1; rodada = 4'd0;
        inicia();
        ate(2600); chk("s3_tocando", {20'b0, leds}, 32'h020);
        @(posedge clock); #1 parar = 1'b1; iniciar = 1'b1;
        @(posedge clock); #1 parar = 1'b0; iniciar = 1'b0;
        fila.delete();
        @(negedge clock); #1;
        chk("s3_parado", {17'b0, leds, buzzer_en, ocupado, pronto}, 32'h0);
        repeat (20) @(negedge clock);

        // Asynchronous reset during the pause, then restart
        mem_n[0] = 4'd7; mem_t[0] = 2'd0; mem_n[1] = 4'd9; mem_t[1] = 2'd0; rodada = 4'd1;
        inicia();
        ate(6000); chk("s4_pausa", {27'b0, leds == 12'h0, ocupado, endereco}, {27'b0, 1'b1, 1'b1, 4'h0});
        reset = 1'b0;
        #1;
        chk("s4_reset_saidas", {17'b0, leds, buzzer_en, ocupado, pronto}, 32'h0);
        chk("s4_reset_end", {28'b0, endereco}, 32'h0);
        fila.delete();
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (5) @(negedge clock);
        rodada = 4'd0;
        inicia();
        ate(2502); chk("s4_reinicio", {16'b0, leds, endereco}, {16'b0, 12'h080, 4'h0});
        espera_fim(30000);

        // Invalid note code: dark but timed
        mem_n[0] = 4'd13; mem_t[0] = 2'd0; rodada = 4'd0;
        inicia();
        chk("s5_modelo_len", fila.size(), 5002);
        ate(2502); chk("s5_escuro", {18'b0, leds, buzzer_en, ocupado}, 32'h1);
        ate(5002); chk("s5_pronto", {31'b0, pronto}, 32'h1);
        espera_fim(30000);

        // Randomized run with spurious start requests and rodada changes while busy
        for (int i = 0; i < 3; i++) begin
            mem_n[i] = 4'($urandom_range(0, 15));
            mem_t[i] = 2'($urandom_range(0, 1));
        end
        rodada      = 4'($urandom_range(0, 2));
        modo_ultima = 1'($urandom_range(0, 1));
        inicia();
        for (int c = 0; c < 40000; c++) begin
            @(posedge clock); #1;
            if (fila.size() <= 5) break;
            iniciar = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 1) rodada = 4'($urandom_range(0, 15));
        end
        iniciar = 1'b0;
        espera_fim(30000);
        modo_ultima = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
